// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : opcodes, sequencer state encodings and IR field positions
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_HALT  = 4'd7
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int OPC_LSB = 27;
  localparam int RA_LSB  = 23;
  localparam int RB_LSB  = 19;
  localparam int RC_LSB  = 15;

  function automatic logic [4:0] ir_opcode(input logic [31:0] ir);
    return ir[OPC_LSB +: 5];
  endfunction

  function automatic logic [3:0] ir_reg(input logic [31:0] ir, input int lsb);
    return ir[lsb +: 4];
  endfunction

  function automatic logic is_alu_op(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_decoder_4to16.sv
// ============================================================================
// reg_decoder_4to16 : 4-bit register index plus enable to one-hot vector
// Rev 1.0
// ============================================================================
`default_nettype none

module reg_decoder_4to16 #(
  parameter int NREGS = 16
) (
  input  logic [3:0]       idx,
  input  logic             en,
  output logic [NREGS-1:0] onehot
);

  for (genvar i = 0; i < NREGS; i++) begin : g_bit
    assign onehot[i] = en && (idx == 4'(i));
  end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// control_unit : hardwired fetch/decode/execute sequencer for the single-bus CPU
// Rev 1.0
// ============================================================================
`default_nettype none

module control_unit
  import cpu_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [31:0]      IR,
  input  logic             MemReady,
  input  logic             Stop,
  output logic             PCout,
  output logic             Zlowout,
  output logic             MDRout,
  output logic             MARin,
  output logic             Zin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             IncPC,
  output logic             Read,
  output logic             ADD,
  output logic             SUB,
  output logic             AND,
  output logic             OR,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout,
  output logic             Run
);

  state_t     state;
  logic [4:0] opcode;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic [3:0] rout_idx;
  logic       rin_en;
  logic       rout_en;
  logic       unused_ir;

  assign opcode    = ir_opcode(IR);
  assign ra        = ir_reg(IR, RA_LSB);
  assign rb        = ir_reg(IR, RB_LSB);
  assign rc        = ir_reg(IR, RC_LSB);
  assign unused_ir = ^IR[14:0];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= S_RESET;
    end else begin
      case (state)
        S_RESET: state <= S_T0;
        S_T0:    state <= S_T1;
        S_T1:    state <= MemReady ? S_T2 : S_T1;
        S_T2: begin
          // A halt opcode wins over the instruction-end Stop check.
          if (is_alu_op(opcode))     state <= S_T3;
          else if (opcode == OP_HALT) state <= S_HALT;
          else                        state <= Stop ? S_HALT : S_T0;
        end
        S_T3:    state <= S_T4;
        S_T4:    state <= S_T5;
        S_T5:    state <= Stop ? S_HALT : S_T0;
        S_HALT:  state <= S_HALT;
        default: state <= S_RESET;
      endcase
    end
  end

  always_comb begin
    PCout   = 1'b0;
    Zlowout = 1'b0;
    MDRout  = 1'b0;
    MARin   = 1'b0;
    Zin     = 1'b0;
    PCin    = 1'b0;
    MDRin   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    ADD     = 1'b0;
    SUB     = 1'b0;
    AND     = 1'b0;
    OR      = 1'b0;
    Run     = 1'b0;
    case (state)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
        Run   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        Run     = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        Run    = 1'b1;
      end
      S_T3: begin
        Yin = 1'b1;
        Run = 1'b1;
      end
      S_T4: begin
        Zin = 1'b1;
        Run = 1'b1;
        ADD = (opcode == OP_ADD);
        SUB = (opcode == OP_SUB);
        AND = (opcode == OP_AND);
        OR  = (opcode == OP_OR);
      end
      S_T5: begin
        Zlowout = 1'b1;
        Run     = 1'b1;
      end
      default: ;
    endcase
  end

  assign rin_en   = (state == S_T5);
  assign rout_en  = (state == S_T3) || (state == S_T4);
  assign rout_idx = (state == S_T3) ? rb : rc;

  reg_decoder_4to16 #(.NREGS(NREGS)) u_rin_dec (
    .idx    (ra),
    .en     (rin_en),
    .onehot (Rin)
  );

  reg_decoder_4to16 #(.NREGS(NREGS)) u_rout_dec (
    .idx    (rout_idx),
    .en     (rout_en),
    .onehot (Rout)
  );

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// tb_control_unit : directed self-checking bench for control_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_control_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] IR;
  logic        MemReady;
  logic        Stop;
  logic        PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read;
  logic        ADD, SUB, AND, OR, Run;
  logic [15:0] Rin, Rout;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] B_PCOUT = 16'h8000, B_ZLO  = 16'h4000, B_MDROUT = 16'h2000;
  localparam logic [15:0] B_MARIN = 16'h1000, B_ZIN  = 16'h0800, B_PCIN   = 16'h0400;
  localparam logic [15:0] B_MDRIN = 16'h0200, B_IRIN = 16'h0100, B_YIN    = 16'h0080;
  localparam logic [15:0] B_INC   = 16'h0040, B_READ = 16'h0020, B_ADD    = 16'h0010;
  localparam logic [15:0] B_SUB   = 16'h0008, B_AND  = 16'h0004, B_OR     = 16'h0002;
  localparam logic [15:0] B_RUN   = 16'h0001;

  localparam logic [15:0] E_T0 = B_PCOUT | B_MARIN | B_INC | B_ZIN | B_RUN;
  localparam logic [15:0] E_T1 = B_ZLO | B_PCIN | B_READ | B_MDRIN | B_RUN;
  localparam logic [15:0] E_T2 = B_MDROUT | B_IRIN | B_RUN;
  localparam logic [15:0] E_T3 = B_YIN | B_RUN;
  localparam logic [15:0] E_T4 = B_ZIN | B_RUN;
  localparam logic [15:0] E_T5 = B_ZLO | B_RUN;

  localparam logic [31:0] I_AND  = 32'h28918000;
  localparam logic [31:0] I_ADD  = 32'h18918000;
  localparam logic [31:0] I_SUB  = 32'h20918000;
  localparam logic [31:0] I_NOP  = 32'hD0000000;
  localparam logic [31:0] I_ILL  = 32'hF8000000;
  localparam logic [31:0] I_HALT = 32'hD8000000;

  control_unit #(.NREGS(16)) dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .MemReady(MemReady), .Stop(Stop),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin), .Zin(Zin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read),
    .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .Rin(Rin), .Rout(Rout), .Run(Run)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] es,
                     input logic [15:0] erin, input logic [15:0] erout);
    logic [47:0] act, exp;
    act = {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read,
           ADD, SUB, AND, OR, Run, Rin, Rout};
    exp = {es, erin, erout};
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed strobes=%h rin=%h rout=%h expected strobes=%h rin=%h rout=%h",
             tag, act[47:32], act[31:16], act[15:0], es, erin, erout);
    end
  endtask

  // Runs one full ALU instruction from T0 (MemReady assumed high), checking each state.
  task automatic alu_instr(input string tag, input logic [15:0] alu_bit);
    chk({tag, "_t0"}, E_T0, 16'h0, 16'h0);
    tick(); chk({tag, "_t1"}, E_T1, 16'h0, 16'h0);
    tick(); chk({tag, "_t2"}, E_T2, 16'h0, 16'h0);
    tick(); chk({tag, "_t3"}, E_T3, 16'h0, 16'h0004);
    tick(); chk({tag, "_t4"}, E_T4 | alu_bit, 16'h0, 16'h0008);
    tick(); chk({tag, "_t5"}, E_T5, 16'h0002, 16'h0);
    tick();
  endtask

  initial begin
    Reset = 1'b1; IR = I_AND; MemReady = 1'b1; Stop = 1'b0;
    tick(); tick();
    chk("reset_state", 16'h0, 16'h0, 16'h0);
    Reset = 1'b0;
    tick();

    // AND with memory ready; next instruction boundary lands in T0.
    alu_instr("and", B_AND);
    chk("and_next_t0", E_T0, 16'h0, 16'h0);

    // Same instruction with three wait cycles in T1.
    MemReady = 1'b0;
    tick(); chk("wait_t1_c1", E_T1, 16'h0, 16'h0);
    tick(); chk("wait_t1_c2", E_T1, 16'h0, 16'h0);
    tick(); chk("wait_t1_c3", E_T1, 16'h0, 16'h0);
    tick(); chk("wait_t1_c4", E_T1, 16'h0, 16'h0);
    MemReady = 1'b1;
    tick(); chk("wait_t2", E_T2, 16'h0, 16'h0);
    tick(); chk("wait_t3", E_T3, 16'h0, 16'h0004);
    tick(); chk("wait_t4", E_T4 | B_AND, 16'h0, 16'h0008);
    tick(); chk("wait_t5", E_T5, 16'h0002, 16'h0);
    tick();

    IR = I_ADD;
    alu_instr("add", B_ADD);
    IR = I_SUB;
    alu_instr("sub", B_SUB);

    IR = I_NOP;
    chk("nop_t0", E_T0, 16'h0, 16'h0);
    tick(); chk("nop_t1", E_T1, 16'h0, 16'h0);
    tick(); chk("nop_t2", E_T2, 16'h0, 16'h0);
    tick();
    IR = I_ILL;
    chk("ill_t0", E_T0, 16'h0, 16'h0);
    tick(); chk("ill_t1", E_T1, 16'h0, 16'h0);
    tick(); chk("ill_t2", E_T2, 16'h0, 16'h0);
    tick(); chk("ill_next_t0", E_T0, 16'h0, 16'h0);

    // Stop pulse that misses the instruction-end edge is ignored.
    IR = I_AND;
    tick(); tick(); tick();
    Stop = 1'b1;
    tick(); Stop = 1'b0;
    tick(); chk("stop_miss_t5", E_T5, 16'h0002, 16'h0);
    tick(); chk("stop_miss_t0", E_T0, 16'h0, 16'h0);

    // Stop held across the T5 edge halts.
    tick(); tick(); tick(); tick(); tick();
    chk("stop_t5", E_T5, 16'h0002, 16'h0);
    Stop = 1'b1;
    tick(); Stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stop_halt_%0d", i), 16'h0, 16'h0, 16'h0);
      tick();
    end

    Reset = 1'b1; tick(); Reset = 1'b0; tick();
    chk("rst_after_stop_t0", E_T0, 16'h0, 16'h0);

    // Halt opcode.
    IR = I_HALT;
    tick(); tick(); chk("halt_t2", E_T2, 16'h0, 16'h0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("halt_op_%0d", i), 16'h0, 16'h0, 16'h0);
      tick();
    end

    // Halt opcode together with Stop.
    Reset = 1'b1; tick(); Reset = 1'b0; tick();
    Stop = 1'b1;
    tick(); tick(); tick();
    chk("halt_stop", 16'h0, 16'h0, 16'h0);
    Stop = 1'b0;

    // Asynchronous reset mid-instruction in T4.
    Reset = 1'b1; tick(); Reset = 1'b0; tick();
    IR = I_AND;
    tick(); tick(); tick(); tick();
    chk("pre_rst_t4", E_T4 | B_AND, 16'h0, 16'h0008);
    #2 Reset = 1'b1;
    #1 chk("async_rst_t4", 16'h0, 16'h0, 16'h0);
    tick(); chk("async_rst_hold", 16'h0, 16'h0, 16'h0);
    Reset = 1'b0;
    tick(); chk("restart_t0", E_T0, 16'h0, 16'h0);
    tick(); chk("restart_t1", E_T1, 16'h0, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/control_unit.md
# control_unit

Hardwired sequencer for the single-bus CPU datapath. It generates every datapath control strobe that a directed bench otherwise drives by hand (PCout, Zlowout, MARin, IRin, register-select lines and so on), cycle by cycle. It runs the fetch phase T0–T2, decodes the instruction register, and runs the execute phase T3–T5 for the three-register ALU instructions. It sits beside `Datapath`, consuming `IR` and a memory ready flag, and drives all of the datapath's control inputs.

## Interface
Parameters:
- `NREGS`, default 16: number of general registers; sets the width of `Rin`/`Rout`.

Ports:
- `Clock`  in  1  system clock; all state changes occur on its rising edge.
- `Reset`  in  1  asynchronous reset, active-high.
- `IR`  in  32  current instruction register contents from the datapath.
- `MemReady`  in  1  memory has valid data on `Mdatain`.
- `Stop`  in  1  request to halt at the next instruction boundary.
- `PCout`, `Zlowout`, `MDRout`, `MARin`, `Zin`, `PCin`, `MDRin`, `IRin`, `Yin`, `IncPC`, `Read`  out  1 each  datapath strobes.
- `ADD`, `SUB`, `AND`, `OR`  out  1 each  ALU operation select; at most one is high at a time.
- `Rin`  out  NREGS  one-hot register load enable.
- `Rout`  out  NREGS  one-hot register bus drive.
- `Run`  out  1  high while the unit is executing instructions.

## Operation
- Instruction fields: opcode = `IR[31:27]`, Ra = `IR[26:23]`, Rb = `IR[22:19]`, Rc = `IR[18:15]`.
- Opcodes: add `5'b00011`, sub `5'b00100`, and `5'b00101`, or `5'b00110`, nop `5'b11010`, halt `5'b11011`.
- Any other opcode executes as nop.
- Moore machine. Outputs are a pure decode of the present state plus the `IR` fields. Every strobe not listed for a state is 0.
- `Reset_state`: all outputs 0. Next state is `T0`.
- `T0`: `PCout`, `MARin`, `IncPC`, `Zin`. Next state is `T1`.
- `T1`: `Zlowout`, `PCin`, `Read`, `MDRin`.
  - Stays in `T1` while `MemReady`=0.
  - Goes to `T2` on the edge where `MemReady`=1.
  - Repeated `PCin` loads are idempotent because Z is unchanged.
- `T2`: `MDRout`, `IRin`.
  - Next state is `T3` for add/sub/and/or.
  - Next state is `Halt` for halt.
  - Next state for nop or an illegal opcode is the instruction-end check.
- `T3`: `Rout[Rb]`, `Yin`. Next state is `T4`.
- `T4`: `Rout[Rc]`, one ALU select per opcode, `Zin`. Next state is `T5`.
- `T5`: `Zlowout`, `Rin[Ra]`. Next state is the instruction-end check.
- Instruction-end check (after `T5`, or after `T2` for nop/illegal): if `Stop`=1, go to `Halt`; otherwise go to `T0`.
- `Halt`: all strobes 0 and `Run`=0. Only `Reset` leaves `Halt`.
- `Run` = 1 in `T0`–`T5`. `Run` = 0 in `Reset_state` and `Halt`.
- Decode reads `IR` from `T3` onward. In `T2`, the next-state decision reads `IR` as it is after the `IRin` edge, i.e. the datapath IR output as sampled at the `T2`→next edge.
- R0 has no special treatment; Ra=0 writes R0.

## Timing
- `Reset` asserted at any time, including mid-instruction: state becomes `Reset_state` and all outputs go to 0 immediately, without waiting for a clock edge.
- The first clock edge after `Reset` deasserts enters `T0`.
- ALU instruction with `MemReady` already high at `T1` entry: 6 cycles (`T0`–`T5`). Each cycle `MemReady` is low adds one cycle.
- nop/illegal: 3 cycles. halt: 3 cycles, then `Halt`.
- `Stop` is sampled only at the instruction-end edge. A `Stop` pulse that does not cover that edge is ignored.
- `Stop` and a halt opcode together: the result is `Halt`.
- State encoding: 4 bits. `Reset_state`=0, `T0`–`T5` = 1–6, `Halt`=7.

## Structure
- Shared package `cpu_pkg`: opcode constants, state encodings, IR field bit positions.
- Sub-module `reg_decoder_4to16` turns a 4-bit register index plus an enable into a one-hot `NREGS` vector.
  - Instantiate it twice: once for `Rin`, once for `Rout`.
  - The `Rout` source is a mux selecting Rb in `T3` and Rc in `T4`.

## Test plan
- Reset, then `IR`=`32'h28918000` (and R1,R2,R3) with `MemReady` held 1:
  - T0–T5 strobes match the lists above.
  - `Rout`=`16'h0004` in `T3`, `Rout`=`16'h0008` in `T4`, `AND`=1, `Rin`=`16'h0002` in `T5`.
  - Next cycle is `T0`.
- Same instruction with `MemReady` low for 3 cycles in `T1`: `T1` lasts 4 cycles with `Read`=`MDRin`=1 throughout; total 9 cycles.
- `IR`=`32'h18918000` (add), then `32'h20918000` (sub): only `ADD`, then only `SUB`, is high in `T4`; all other ALU selects are 0.
- `IR`=`32'hD0000000` (nop) and `32'hF8000000` (illegal, opcode `5'b11111`): `T0`→`T1`→`T2`→`T0`; `Rin` is 0 for all cycles.
- `IR`=`32'hD8000000` (halt), and separately `Stop`=1 during `T5` of an and: `Halt` is entered, `Run`=0, and outputs stay 0 for 10+ cycles until `Reset`.
- `Reset` pulsed during `T4`: outputs are 0 before the next edge, and execution restarts at `T0` after release.
